delay_meas_ctrl: RTL and testbench
==================================

Name: delay_meas_ctrl

Overview:
Measurement controller that sits directly upstream and downstream of a testchain delay line. It drives the chain input (`launch`), synchronises the chain output (`chain_in`), and counts the clk cycles from each launched rising edge to its arrival. It repeats this over 2^LOG_RUNS runs and reports the truncated average, so chain delay can be characterised from the dedicated I/O pins.

Parameters:
- CNT_W, 16, width of the per-run cycle counter and of `result`/`last_cnt`.
- LOG_RUNS, 3, log2 of the number of runs averaged per measurement.
- TIMEOUT, 1000, cycle limit for any single wait phase; must be ≤ 2^CNT_W−2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle request; accepted only in IDLE.
- launch  out  1  registered drive into the delay chain din.
- chain_in  in  1  delay chain dout; asynchronous to clk.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a measurement finishes (normal or timeout).
- timeout  out  1  sticky error flag; cleared on the next accepted start.
- result  out  CNT_W  average cycles per run = acc >> LOG_RUNS; all-ones after a timeout.
- last_cnt  out  CNT_W  count from the most recent completed run.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - launch, done, busy, timeout = 0.
  - result, last_cnt, cnt, acc, run = 0.
  - Synchroniser flops = 0.
  - Reset mid-measurement aborts at once; launch falls asynchronously.
- Synchronisation: `chain_in` passes through 2 flops to give `chain_s`; the FSM uses only `chain_s`.
- Widths:
  - cnt is CNT_W bits.
  - acc is CNT_W+LOG_RUNS bits, so it cannot overflow.
  - run is LOG_RUNS+1 bits.
- States:
  - IDLE:
    - start=1 → SETTLE.
    - On that edge: launch←0, cnt←0, acc←0, run←0, timeout←0.
  - SETTLE (launch=0; waits for the chain to drain low):
    - chain_s=0 → RISE; launch←1, cnt←0.
    - Else if cnt==TIMEOUT → DONE; timeout←1, result←all-ones.
    - Else cnt←cnt+1.
  - RISE (launch=1):
    - chain_s=1 → acc←acc+cnt, last_cnt←cnt, run←run+1.
      - If run+1 == 2^LOG_RUNS → DONE.
      - Else → SETTLE with launch←0, cnt←0.
    - Else if cnt==TIMEOUT → DONE; timeout←1, launch←0, result←all-ones.
    - Else cnt←cnt+1.
  - DONE (lasts exactly 1 cycle):
    - done=1, launch←0.
    - If timeout=0, result←acc>>LOG_RUNS (truncating).
    - → IDLE.
- Count definition:
  - The counter is 0 on the edge where launch rises.
  - The captured value is 2 for a zero-delay loopback (synchroniser latency).
  - Each additional registered cycle of delay adds 1.
- Timing: busy is registered and goes high the cycle after start is sampled.
- start while busy: ignored, with no effect on an in-progress run.
- start and chain transitions in the same cycle in IDLE: chain_s is ignored in IDLE.
- No wrap-around: cnt never exceeds TIMEOUT; acc is sized for the worst case.
- result and last_cnt hold their values until overwritten by the next measurement.

Decomposition:
- delay_meas_pkg holds:
  - state enum {IDLE, SETTLE, RISE, DONE};
  - localparam SYNC_STAGES=2;
  - helper function acc_width(CNT_W, LOG_RUNS).
- One sub-module, sync2: a 2-flop synchroniser with async active-low reset to 0. It is reused for any other asynchronous chain taps.

Test Plan:
- Zero-delay loopback (chain_in=launch), LOG_RUNS=3, start pulse → 8 runs; result=2, last_cnt=2, timeout=0; exactly one done pulse; busy drops the cycle after done.
- 5-flop registered delay model in the loop → result=7, last_cnt=7.
- Run-varying delay of 0..7 extra cycles across the 8 runs → acc=16+28=44, result=5 (truncation checked).
- chain_in tied 0, TIMEOUT=20 → timeout=1 and done after RISE has counted to 20; result=16'hFFFF; launch=0 after DONE.
- chain_in tied 1 → timeout raised during SETTLE; launch never goes high.
- start pulsed while busy, and rst_n asserted mid-RISE → second start ignored; on reset, launch/busy/done/result all read 0 immediately; a fresh start afterwards completes normally with result=2.

Source files
------------

// File: rtl/delay_meas_pkg.sv
// Shared types and helpers for the delay measurement controller.
// Holds the FSM state encoding, synchroniser depth and width helper.
package delay_meas_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    RISE,
    DONE
  } state_t;

  localparam int SYNC_STAGES = 2;

  // Accumulator needs LOG_RUNS extra bits so 2^LOG_RUNS
  // full-scale counts cannot overflow it.
  function automatic int acc_width(input int cnt_w,
                                   input int log_runs);
    return cnt_w + log_runs;
  endfunction

endpackage

// File: rtl/delay_meas_ctrl_sync2.sv
// Two-flop synchroniser with async active-low reset to 0.
// Ports: clk, rst_n, d (async in), q (synchronised out).
module sync2
  import delay_meas_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[SYNC_STAGES-2:0], d};
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/delay_meas_ctrl.sv
// Delay-chain measurement controller: launches edges, counts arrival cycles.
// Ports: clk, rst_n, start, launch, chain_in, busy, done, timeout, result, last_cnt.
module delay_meas_ctrl
  import delay_meas_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int LOG_RUNS = 3,
  parameter int TIMEOUT  = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             launch,
  input  logic             chain_in,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] result,
  output logic [CNT_W-1:0] last_cnt
);

  localparam int ACC_W = acc_width(CNT_W, LOG_RUNS);
  localparam int RUN_W = LOG_RUNS + 1;
  localparam logic [RUN_W-1:0] RUNS = RUN_W'(2 ** LOG_RUNS);
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  state_t             state, state_nxt;
  logic               chain_s;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [ACC_W-1:0]   acc, acc_nxt;
  logic [RUN_W-1:0]   run, run_nxt;
  logic               launch_nxt;
  logic               busy_nxt;
  logic               done_nxt;
  logic               timeout_nxt;
  logic [CNT_W-1:0]   result_nxt;
  logic [CNT_W-1:0]   last_nxt;

  sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (chain_in),
    .q     (chain_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      run      <= '0;
      launch   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      result   <= '0;
      last_cnt <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      acc      <= acc_nxt;
      run      <= run_nxt;
      launch   <= launch_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      timeout  <= timeout_nxt;
      result   <= result_nxt;
      last_cnt <= last_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    acc_nxt     = acc;
    run_nxt     = run;
    launch_nxt  = launch;
    timeout_nxt = timeout;
    result_nxt  = result;
    last_nxt    = last_cnt;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = SETTLE;
          launch_nxt  = 1'b0;
          cnt_nxt     = '0;
          acc_nxt     = '0;
          run_nxt     = '0;
          timeout_nxt = 1'b0;
        end
      end
      SETTLE: begin
        if (!chain_s) begin
          state_nxt  = RISE;
          launch_nxt = 1'b1;
          cnt_nxt    = '0;
        end else if (cnt == TO_CNT) begin
          state_nxt   = DONE;
          timeout_nxt = 1'b1;
          result_nxt  = '1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RISE: begin
        if (chain_s) begin
          acc_nxt  = acc + ACC_W'(cnt);
          last_nxt = cnt;
          run_nxt  = run + 1'b1;
          if (run_nxt == RUNS) begin
            state_nxt = DONE;
          end else begin
            state_nxt  = SETTLE;
            launch_nxt = 1'b0;
            cnt_nxt    = '0;
          end
        end else if (cnt == TO_CNT) begin
          state_nxt   = DONE;
          timeout_nxt = 1'b1;
          launch_nxt  = 1'b0;
          result_nxt  = '1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE: begin
        launch_nxt = 1'b0;
        state_nxt  = IDLE;
        if (!timeout)
          result_nxt = CNT_W'(acc >> LOG_RUNS);
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == DONE);
  end

endmodule

// File: tb/tb_delay_meas_ctrl.sv
// Scoreboard bench for delay_meas_ctrl with a behavioural chain model.
// Stimulus pushes expected outcomes; a monitor pops them when busy falls.
module tb_delay_meas_ctrl;

  localparam int CNT_W = 16;
  localparam int LOGR  = 3;
  localparam int NRUN  = 8;
  localparam int TO    = 20;

  typedef struct {
    logic [15:0] res;
    logic [15:0] last;
    logic        to;
    int          blen;
    bit          no_launch;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             launch;
  logic             chain_in;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] result;
  logic [CNT_W-1:0] last_cnt;

  int          checks;
  int          errors;
  exp_t        sbq[$];
  bit          fin;
  int          mode;
  int          depth;
  int          sched[NRUN];
  logic [15:0] last_ref;
  logic [7:0]  sh;

  delay_meas_ctrl #(
    .CNT_W    (CNT_W),
    .LOG_RUNS (LOGR),
    .TIMEOUT  (TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .launch   (launch),
    .chain_in (chain_in),
    .busy     (busy),
    .done     (done),
    .timeout  (timeout),
    .result   (result),
    .last_cnt (last_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Chain model: a tapped line of registered delays after launch.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) sh <= '0;
    else        sh <= {sh[6:0], launch};
  end

  always_comb begin
    chain_in = 1'b0;
    if (mode == 2)      chain_in = 1'b1;
    else if (mode == 0) chain_in = (depth == 0) ? launch : sh[depth-1];
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Monitor: reset checks, pulse tracking, scoreboard pop.
  initial begin
    bit   busy_q;
    bit   done_q;
    bit   rst_q;
    bit   lseen;
    int   blen;
    int   ndone;
    exp_t e;
    busy_q = 0; done_q = 0; rst_q = 1;
    lseen = 0; blen = 0; ndone = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        if (rst_q) begin
          chk("rst_launch", 32'(launch), 32'd0);
          chk("rst_busy", 32'(busy), 32'd0);
          chk("rst_done", 32'(done), 32'd0);
          chk("rst_timeout", 32'(timeout), 32'd0);
          chk("rst_result", 32'(result), 32'd0);
          chk("rst_last", 32'(last_cnt), 32'd0);
        end
        rst_q = 0; busy_q = 0; done_q = 0;
        lseen = 0; blen = 0; ndone = 0;
      end else begin
        rst_q = 1;
        if (busy) begin
          blen++;
          if (done) ndone++;
          if (launch) lseen = 1;
        end
        if (busy_q && !busy) begin
          if (sbq.size() == 0) begin
            chk("unexpected_meas", 32'd1, 32'd0);
          end else begin
            e = sbq.pop_front();
            chk("result", 32'(result), 32'(e.res));
            chk("last_cnt", 32'(last_cnt), 32'(e.last));
            chk("timeout", 32'(timeout), 32'(e.to));
            chk("done_pulses", 32'(ndone), 32'd1);
            chk("done_before_idle", 32'(done_q), 32'd1);
            chk("done_low_idle", 32'(done), 32'd0);
            chk("launch_idle", 32'(launch), 32'd0);
            if (e.blen >= 0)
              chk("busy_len", 32'(blen), 32'(e.blen));
            if (e.no_launch)
              chk("launch_seen", 32'(lseen), 32'd0);
          end
          lseen = 0; blen = 0; ndone = 0;
        end
        done_q = done;
        busy_q = busy;
      end
      if (fin) begin
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  // Reference: each run costs 2 sync cycles plus its extra delay.
  function automatic exp_t model_norm();
    exp_t e;
    int   acc;
    acc = 0;
    for (int i = 0; i < NRUN; i++) acc += 2 + sched[i];
    e.res       = 16'(acc / NRUN);
    e.last      = 16'(2 + sched[NRUN-1]);
    e.to        = 1'b0;
    e.blen      = -1;
    e.no_launch = 0;
    return e;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_meas(input bit extra);
    int  idx;
    bit  lp;
    int  n;
    idx = 0;
    depth = sched[0];
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lp = launch;
    n = 0;
    while (busy) begin
      @(negedge clk);
      if (lp && !launch && idx < NRUN-1) begin
        idx++;
        depth = sched[idx];
      end
      lp = launch;
      if (extra) start = (n == 4 || n == 20);
      n++;
      if (n > 3000) begin
        $display("FAIL meas_budget actual=busy required=idle");
        $fatal(1);
      end
    end
    start = 1'b0;
    idle(12);
  endtask

  task automatic norm_meas(input bit extra);
    exp_t e;
    e = model_norm();
    last_ref = e.last;
    sbq.push_back(e);
    run_meas(extra);
  endtask

  task automatic to_meas(input int m, input int bl, input bit nl);
    exp_t e;
    mode = m;
    idle(6);
    e.res = 16'hFFFF;
    e.last = last_ref;
    e.to = 1'b1;
    e.blen = bl;
    e.no_launch = nl;
    sbq.push_back(e);
    run_meas(0);
    mode = 0;
    idle(6);
  endtask

  initial begin
    int prev;
    int hi;
    checks = 0; errors = 0; fin = 0;
    rst_n = 1'b0; start = 1'b0;
    mode = 0; depth = 0; last_ref = '0;
    for (int i = 0; i < NRUN; i++) sched[i] = 0;
    idle(3);
    rst_n = 1'b1;
    idle(3);

    for (int i = 0; i < NRUN; i++) sched[i] = 0;
    norm_meas(0);
    for (int i = 0; i < NRUN; i++) sched[i] = 5;
    norm_meas(0);
    for (int i = 0; i < NRUN; i++) sched[i] = i;
    norm_meas(0);

    for (int k = 0; k < 5; k++) begin
      prev = int'($urandom_range(0, 7));
      sched[0] = prev;
      for (int i = 1; i < NRUN; i++) begin
        hi = (prev + 3 > 7) ? 7 : prev + 3;
        prev = int'($urandom_range(0, hi));
        sched[i] = prev;
      end
      norm_meas(0);
    end

    to_meas(1, 23, 0);
    to_meas(2, 22, 1);

    for (int i = 0; i < NRUN; i++) sched[i] = 0;
    norm_meas(1);

    depth = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int n = 0; n < 200 && !launch; n++) @(posedge clk);
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    last_ref = '0;
    idle(15);
    norm_meas(0);

    idle(4);
    fin = 1;
    idle(4);
    $display("FAIL monitor_end actual=running required=finished");
    $fatal(1);
  end

endmodule
